uart_frame_check: RTL and testbench
===================================

Name: uart_frame_check

Overview:
- Downstream consumer of the RX bit-sampling stage.
- Captures each completed frame vector on the sampler's done indication and checks the start, parity and stop bits.
- Frames that pass the checks go into a small first-word-fall-through FIFO. The FIFO is read with a valid/ready handshake by the register file or host logic.
- Error pulses and a sticky overflow flag go to the status path.

Parameters:
- DATA_W, 8, payload bits per frame. Parity frame is DATA_W+3 bits; no-parity frame is DATA_W+2 bits.
- FIFO_DEPTH, 4, entries in the output FIFO; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- frame_done  in  1  done level from sampler; a rising edge marks a complete frame
- data_parity  in  DATA_W+3  frame with parity: bit0 start, bits1..DATA_W data LSB-first, bit DATA_W+1 parity, MSB stop
- data_no_parity  in  DATA_W+2  frame without parity: bit0 start, bits1..DATA_W data, MSB stop
- PAR_EN  in  1  1 = use data_parity, 0 = use data_no_parity
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- err_clr  in  1  synchronous clear of the sticky overflow flag
- dout  out  DATA_W  FIFO head data
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer accepts head when high with dout_valid
- strt_err  out  1  one-cycle pulse: start bit was 1
- par_err  out  1  one-cycle pulse: parity mismatch (only when PAR_EN)
- stp_err  out  1  one-cycle pulse: stop bit was 0
- ovf_err  out  1  sticky: good frame dropped because FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, async): FSM=IDLE, FIFO empty, pointers 0, capture register 0, all outputs 0, frame_done history register 0.
- Edge detect: register frame_done each cycle; edge = frame_done & ~prev. Level-held done never retriggers.
- FSM IDLE: on edge, latch PAR_EN, PAR_TYP and the selected frame vector into the capture register; go to CHECK.
- FSM CHECK (exactly 1 cycle):
  - strt_err = (bit0==1).
  - stp_err = (MSB==0).
  - par_err = PAR_EN & (XOR(data bits, parity bit) != PAR_TYP).
  - The three error flags pulse in this cycle.
  - Frame is good if no flag is set. A good frame pushes data bits into the FIFO at end of cycle.
  - A bad frame is dropped. A good frame with the FIFO full and no simultaneous pop is dropped and sets ovf_err.
  - Always return to IDLE.
- Edge-to-push latency: edge seen at cycle t, errors valid and push at t+1, dout_valid high at t+2 if FIFO was empty.
- Back-to-back edges cannot occur closer than 2 cycles, so no edge is ever missed in CHECK.
- FIFO: first-word fall-through; dout = mem[rd_ptr]; pop when dout_valid & dout_ready.
  - Pop while empty is ignored.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop when empty: count +1 (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- ovf_err: set on drop-when-full, cleared by err_clr. Set wins if both occur in the same cycle.
- dout holds its value when the FIFO is empty; dout is 0 after reset.
- PAR_EN/PAR_TYP changes outside the capture cycle have no effect on the frame being checked.

Optional Feature:
- Macro UART_ERR_CNT_EN.
- Defined:
  - Adds outputs err_cnt_par, err_cnt_stp and err_cnt_ovf, each 8 bits.
  - Each counter increments on its error event, saturates at 255, is cleared by err_clr and is 0 on reset.
  - A strt_err frame counts into err_cnt_stp.
- Undefined: ports and logic are absent; other behaviour is identical.

Test Plan:
- PAR_EN=0, frame 10'b1_10100101_0, edge -> no error pulses; dout=8'hA5, dout_valid=1 two cycles after edge; pop with dout_ready -> dout_valid=0.
- PAR_EN=1, PAR_TYP=0, data 8'h03, parity 0, stop 1 -> accepted. Same with parity 1 -> par_err one-cycle pulse, nothing pushed.
- Stop bit 0 -> stp_err pulse; start bit 1 -> strt_err pulse; fifo_count unchanged in both cases.
- Push 5 good frames with dout_ready=0, FIFO_DEPTH=4 -> fifo_count=4, ovf_err=1; assert err_clr -> ovf_err=0; drain yields the first 4 bytes in order.
- FIFO full and dout_ready=1 in the CHECK cycle of a good frame -> push accepted, fifo_count stays 4, ovf_err stays 0.
- rst pulled low mid-CHECK with 2 entries queued -> all outputs 0 immediately; after release, frame_done held high produces no new push.

Source files
------------

// File: rtl/uart_frame_check.sv
// uart_frame_check: frame checker and output FIFO behind the UART RX sampler.
// Detects the rising edge of the sampler's done level and captures the frame.
// Checks the start, parity and stop bits in a single CHECK cycle.
// Pushes good payloads into a first-word-fall-through FIFO read with valid/ready.
// Optional feature macro: UART_ERR_CNT_EN adds saturating 8-bit error counters
// (err_cnt_par, err_cnt_stp, err_cnt_ovf).
module uart_frame_check #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_done,
  input  logic [DATA_W+2:0]               data_parity,
  input  logic [DATA_W+1:0]               data_no_parity,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            err_clr,
  output logic [DATA_W-1:0]               dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            strt_err,
  output logic                            par_err,
  output logic                            stp_err,
  output logic                            ovf_err,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
`ifdef UART_ERR_CNT_EN
  ,
  output logic [7:0]                      err_cnt_par,
  output logic [7:0]                      err_cnt_stp,
  output logic [7:0]                      err_cnt_ovf
`endif
);

  localparam int PW = DATA_W + 3;
  localparam int NW = DATA_W + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Done-level history and an arm flag: the arm flag only sets once frame_done
  // has been seen low after reset, so a done level still held across reset is
  // not mistaken for a new frame.
  logic done_prev_reg;
  logic armed_reg;
  logic done_edge;

  // Capture register holds the frame normalised to the parity layout.
  logic [PW-1:0] cap_frame_reg;
  logic          cap_par_en_reg;
  logic          cap_par_typ_reg;
  logic          capture;

  logic              cap_start;
  logic [DATA_W-1:0] cap_data;
  logic              cap_par;
  logic              cap_stop;

  logic strt_flag, par_flag, stp_flag;
  logic frame_good;

  // FIFO state
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              ovf_reg, ovf_next;

  logic fifo_full;
  logic fifo_nonempty;
  logic pop;
  logic push;
  logic drop_full;

  assign done_edge = frame_done & ~done_prev_reg & armed_reg;

  assign cap_start = cap_frame_reg[0];
  assign cap_data  = cap_frame_reg[DATA_W:1];
  assign cap_par   = cap_frame_reg[DATA_W+1];
  assign cap_stop  = cap_frame_reg[DATA_W+2];

  // State register, done-edge history and frame capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      done_prev_reg   <= 1'b0;
      armed_reg       <= 1'b0;
      cap_frame_reg   <= '0;
      cap_par_en_reg  <= 1'b0;
      cap_par_typ_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      done_prev_reg <= frame_done;
      armed_reg     <= armed_reg | ~frame_done;
      if (capture) begin
        cap_par_en_reg  <= PAR_EN;
        cap_par_typ_reg <= PAR_TYP;
        if (PAR_EN) begin
          cap_frame_reg <= data_parity;
        end else begin
          cap_frame_reg <= {data_no_parity[NW-1], 1'b0, data_no_parity[NW-2:0]};
        end
      end
    end
  end

  // Next-state logic and the per-frame error checks.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    strt_flag  = 1'b0;
    par_flag   = 1'b0;
    stp_flag   = 1'b0;
    frame_good = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (done_edge) begin
          capture    = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        strt_flag  = cap_start;
        stp_flag   = ~cap_stop;
        par_flag   = cap_par_en_reg & ((^{cap_data, cap_par}) != cap_par_typ_reg);
        frame_good = ~(strt_flag | par_flag | stp_flag);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign strt_err = strt_flag;
  assign par_err  = par_flag;
  assign stp_err  = stp_flag;

  assign fifo_nonempty = (count_reg != '0);
  assign fifo_full     = (count_reg == CW'(FIFO_DEPTH));
  assign pop           = fifo_nonempty & dout_ready;
  assign push          = frame_good & (~fifo_full | pop);
  assign drop_full     = frame_good & fifo_full & ~pop;

  // FIFO pointer, occupancy, head and overflow next-state logic.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    dout_next   = dout_reg;
    ovf_next    = ovf_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end

    // Head register tracks mem[rd_ptr]; the word being written this cycle is
    // forwarded when it becomes the new head. An empty FIFO keeps the last head.
    if (count_next != '0) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
        dout_next = cap_data;
      end else begin
        dout_next = mem[rd_ptr_next];
      end
    end

    // A drop sets the flag even when err_clr is asserted in the same cycle.
    if (drop_full) begin
      ovf_next = 1'b1;
    end else if (err_clr) begin
      ovf_next = 1'b0;
    end
  end

  // FIFO storage write port (no reset, maps onto RAM).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cap_data;
    end
  end

  // FIFO control registers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= dout_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = fifo_nonempty;
  assign fifo_count = count_reg;
  assign ovf_err    = ovf_reg;

`ifdef UART_ERR_CNT_EN
  // Counter 0: parity, 1: start/stop framing, 2: overflow drops.
  logic [2:0] cnt_event;
  logic [7:0] cnt_reg [3];

  assign cnt_event[0] = par_flag;
  assign cnt_event[1] = strt_flag | stp_flag;
  assign cnt_event[2] = drop_full;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_err_cnt
      // Saturating error counter; err_clr takes priority over a new event.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi] <= 8'd0;
        end else if (err_clr) begin
          cnt_reg[gi] <= 8'd0;
        end else if (cnt_event[gi] && (cnt_reg[gi] != 8'hFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
        end
      end
    end
  endgenerate

  assign err_cnt_par = cnt_reg[0];
  assign err_cnt_stp = cnt_reg[1];
  assign err_cnt_ovf = cnt_reg[2];
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
// tb_uart_frame_check: directed self-checking bench for uart_frame_check
// (default build, DATA_W=8, FIFO_DEPTH=4).
module tb_uart_frame_check;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              frame_done;
  logic [10:0]       data_parity;
  logic [9:0]        data_no_parity;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              err_clr;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              strt_err;
  logic              par_err;
  logic              stp_err;
  logic              ovf_err;
  logic [2:0]        fifo_count;

  int checks = 0;
  int errors = 0;

  uart_frame_check #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_done     (frame_done),
    .data_parity    (data_parity),
    .data_no_parity (data_no_parity),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .err_clr        (err_clr),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .strt_err       (strt_err),
    .par_err        (par_err),
    .stp_err        (stp_err),
    .ovf_err        (ovf_err),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_p(input logic [7:0] d, input logic par,
                                       input logic start, input logic stop);
    return {stop, par, d, start};
  endfunction

  function automatic logic [9:0] mk_np(input logic [7:0] d, input logic start, input logic stop);
    return {stop, d, start};
  endfunction

  // One frame: edge in cycle t, flags checked in CHECK (t+1), pulse end checked at t+2.
  // PAR_EN/PAR_TYP are inverted after capture to prove they were latched.
  task automatic do_frame(input string tag, input logic pe, input logic pt,
                          input logic [10:0] vp, input logic [9:0] vn, input logic rdy,
                          input logic es, input logic ep, input logic et);
    @(posedge clk); #1;
    PAR_EN         = pe;
    PAR_TYP        = pt;
    data_parity    = vp;
    data_no_parity = vn;
    frame_done     = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    PAR_EN     = ~pe;
    PAR_TYP    = ~pt;
    dout_ready = rdy;
    check({tag, ".strt"}, 32'(strt_err), 32'(es));
    check({tag, ".par"},  32'(par_err),  32'(ep));
    check({tag, ".stp"},  32'(stp_err),  32'(et));
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check({tag, ".pulse_end"}, 32'({strt_err, par_err, stp_err}), 32'd0);
    $display("frame %s: pe=%0b pt=%0b count=%0d valid=%0b dout=%02h ovf=%0b",
             tag, pe, pt, fifo_count, dout_valid, dout, ovf_err);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, ".valid"}, 32'(dout_valid), 32'd1);
    check({tag, ".dout"},  32'(dout),       32'(exp));
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    $display("pop %s: dout=%02h count_after=%0d", tag, exp, fifo_count);
  endtask

  initial begin
    rst            = 1'b0;
    frame_done     = 1'b0;
    data_parity    = '0;
    data_no_parity = '0;
    PAR_EN         = 1'b0;
    PAR_TYP        = 1'b0;
    err_clr        = 1'b0;
    dout_ready     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.dout",  32'(dout),       32'd0);
    check("rst.valid", 32'(dout_valid), 32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.flags", 32'({strt_err, par_err, stp_err, ovf_err}), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // No-parity frame 10'b1_10100101_0, with latency check
    @(posedge clk); #1;
    PAR_EN         = 1'b0;
    data_no_parity = 10'b1_10100101_0;
    frame_done     = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    check("np.check_flags", 32'({strt_err, par_err, stp_err}), 32'd0);
    check("np.valid_t1",    32'(dout_valid), 32'd0);
    @(posedge clk); #1;
    check("np.valid_t2", 32'(dout_valid), 32'd1);
    check("np.count",    32'(fifo_count), 32'd1);
    pop_check("np.pop", 8'hA5);
    check("np.empty",     32'(dout_valid), 32'd0);
    check("np.dout_hold", 32'(dout),       32'hA5);

    // Parity frames
    do_frame("par_even_ok",  1'b1, 1'b0, mk_p(8'h03, 1'b0, 1'b0, 1'b1), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("par_even_ok.count", 32'(fifo_count), 32'd1);
    pop_check("par_even_ok.pop", 8'h03);
    do_frame("par_even_bad", 1'b1, 1'b0, mk_p(8'h03, 1'b1, 1'b0, 1'b1), '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_even_bad.count", 32'(fifo_count), 32'd0);
    do_frame("par_odd_ok",   1'b1, 1'b1, mk_p(8'h5A, 1'b1, 1'b0, 1'b1), '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("par_odd_ok.count", 32'(fifo_count), 32'd1);
    pop_check("par_odd_ok.pop", 8'h5A);

    // Framing errors
    do_frame("stop0",  1'b0, 1'b0, '0, mk_np(8'h3C, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1);
    check("stop0.count", 32'(fifo_count), 32'd0);
    do_frame("start1", 1'b0, 1'b0, '0, mk_np(8'h3C, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0, 1'b0);
    check("start1.count", 32'(fifo_count), 32'd0);

    // Overflow: five good frames into a depth-4 FIFO
    do_frame("fill1", 1'b0, 1'b0, '0, mk_np(8'h11, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("fill2", 1'b0, 1'b0, '0, mk_np(8'h22, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("fill3", 1'b0, 1'b0, '0, mk_np(8'h33, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("fill4", 1'b0, 1'b0, '0, mk_np(8'h44, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill4.count", 32'(fifo_count), 32'd4);
    check("fill4.ovf",   32'(ovf_err),    32'd0);
    do_frame("fill5", 1'b0, 1'b0, '0, mk_np(8'h55, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill5.count", 32'(fifo_count), 32'd4);
    check("fill5.ovf",   32'(ovf_err),    32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("errclr.ovf", 32'(ovf_err), 32'd0);
    pop_check("drain1", 8'h11);
    pop_check("drain2", 8'h22);
    pop_check("drain3", 8'h33);
    pop_check("drain4", 8'h44);
    check("drain.empty", 32'(dout_valid), 32'd0);

    // Full FIFO with a pop in the CHECK cycle of a good frame
    do_frame("refill1", 1'b0, 1'b0, '0, mk_np(8'hA1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("refill2", 1'b0, 1'b0, '0, mk_np(8'hA2, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("refill3", 1'b0, 1'b0, '0, mk_np(8'hA3, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("refill4", 1'b0, 1'b0, '0, mk_np(8'hA4, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("fullpop", 1'b0, 1'b0, '0, mk_np(8'hA5, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    check("fullpop.count", 32'(fifo_count), 32'd4);
    check("fullpop.ovf",   32'(ovf_err),    32'd0);
    pop_check("fp_drain1", 8'hA2);
    pop_check("fp_drain2", 8'hA3);
    check("fp.count2", 32'(fifo_count), 32'd2);

    // Reset asserted during CHECK with two entries queued
    @(posedge clk); #1;
    PAR_EN         = 1'b0;
    data_no_parity = mk_np(8'h77, 1'b0, 1'b1);
    frame_done     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst.count", 32'(fifo_count), 32'd0);
    check("midrst.valid", 32'(dout_valid), 32'd0);
    check("midrst.dout",  32'(dout),       32'd0);
    check("midrst.flags", 32'({strt_err, par_err, stp_err, ovf_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("held_done.count", 32'(fifo_count), 32'd0);
    check("held_done.valid", 32'(dout_valid), 32'd0);
    frame_done = 1'b0;
    @(posedge clk);

    // Recovery after reset
    do_frame("recover", 1'b0, 1'b0, '0, mk_np(8'hC3, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
    check("recover.count", 32'(fifo_count), 32'd1);
    pop_check("recover.pop", 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
